eth_frame_detector_mem_arbiter: RTL and testbench
=================================================

Name: eth_frame_detector_mem_arbiter

Overview:
- Shares one pattern-memory port (req/we/ack handshake, word addressing) between C_NUM_REQ requesters.
- Typical requesters: the AXI DRAM bridge that writes and reads back patterns, and the frame comparator that fetches pattern words.
- Round-robin arbitration, one transaction in flight, ack timeout with error return.
- Sits between the requesters and one dual-port memory port, replacing the direct point-to-point connection.

Parameters:
- C_DATA_WIDTH, 32, memory word width.
- C_ADDR_WIDTH, 11, memory word address width.
- C_NUM_REQ, 2, number of requesters (2..8).
- C_TIMEOUT, 255, max cycles waiting for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  C_NUM_REQ  request pending, one bit per requester.
- req_we  in  C_NUM_REQ  1 = write, 0 = read.
- req_addr  in  C_NUM_REQ*C_ADDR_WIDTH  flattened addresses; requester i at [i*AW +: AW].
- req_wdata  in  C_NUM_REQ*C_DATA_WIDTH  flattened write data.
- req_ack  out  C_NUM_REQ  one-cycle completion pulse, one-hot.
- req_err  out  1  valid with req_ack; 1 = timed out.
- req_rdata  out  C_DATA_WIDTH  read data, valid with req_ack.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  memory write enable.
- mem_ack  in  1  memory completion, one cycle.
- mem_addr  out  C_ADDR_WIDTH  memory address.
- mem_wdata  out  C_DATA_WIDTH  memory write data.
- mem_rdata  in  C_DATA_WIDTH  read data, valid with mem_ack.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; last_grant = C_NUM_REQ-1, so requester 0 wins first.
- Requester rules: hold req_valid and operands stable until req_ack; drop req_valid, or present a new request, the cycle after req_ack.
- IDLE: if any req_valid is set, choose the first set bit searching from last_grant+1 with wrap. Register the winner's grant index, we, addr and wdata; update last_grant; go to ISSUE.
- ISSUE: mem_req=1 and mem_we/addr/wdata driven from the registered copies. The timeout counter starts at 0 and increments each cycle.
  - mem_ack=1: capture mem_rdata (0 on writes), req_err=0, go to DONE.
  - Counter reaches C_TIMEOUT-1 with no ack (C_TIMEOUT≠0): drop mem_req, rdata=0, req_err=1, go to DONE.
- DONE: req_ack[grant]=1 for exactly one cycle; req_rdata and req_err hold until the next DONE; go to IDLE.
- Latency: valid at cycle 0 → mem_req at cycle 1 → mem_ack at cycle k≥1 → req_ack at k+1. Minimum 2 cycles; back-to-back throughput is one transaction per 3 cycles.
- mem_ack outside ISSUE (a late ack after timeout) is ignored and does not corrupt req_rdata.
- Fairness: no requester is granted twice while another has valid continuously asserted.
- A requester dropping req_valid in ISSUE is a protocol violation; the transaction still completes and acks.
- Reset mid-transaction: mem_req drops immediately; no ack is issued.

Optional Feature:
- Macro: ETH_FRAME_DETECTOR_ARB_STATS_EN.
- Defined: adds input stat_clr (1), output stat_grants (C_NUM_REQ*32), and output stat_timeouts (16).
  - stat_grants: per-requester grant counters, +1 on each IDLE→ISSUE for that requester.
  - stat_timeouts: +1 per timeout.
  - All counters saturate; reset to 0 on reset or on stat_clr (synchronous, one cycle). Clear wins over a simultaneous increment.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package eth_frame_detector_arb_pkg:
  - typedef enum {IDLE, ISSUE, DONE} arb_state_t.
  - Timeout counter width function: $clog2(C_TIMEOUT+1).
  - Stats counter widths (32, 16).
- Sub-module rr_priority_picker (combinational, parameter N): inputs req and last; outputs a one-hot grant and its index.

Test Plan:
- Single read, requester 0 addr 0x123, memory acks after 3 cycles with 0xDEADBEEF → mem_addr=0x123, mem_we=0, req_ack=01 at cycle 5, req_rdata=0xDEADBEEF, req_err=0.
- Both requesters hold valid for 6 transactions, memory acks in 1 cycle → grants alternate 0,1,0,1,0,1; req_ack pulses every 3 cycles.
- Write from requester 1, addr 0x7FF, data 0x0000A5A5 → mem_we=1, mem_wdata=0x0000A5A5 until ack, then req_ack=10.
- C_TIMEOUT=4, memory never acks → mem_req high for exactly 4 cycles, then req_ack with req_err=1, rdata=0. A late mem_ack 2 cycles later is ignored.
- Reset asserted during ISSUE → mem_req=0 immediately, no req_ack. After release, requester 0 is granted first.
- With ETH_FRAME_DETECTOR_ARB_STATS_EN: 3 grants to requester 0 and 1 timeout → stat_grants[0]=3, stat_timeouts=1. After stat_clr pulse, both read 0.

Source files
------------

// File: rtl/eth_frame_detector_arb_pkg.sv
// eth_frame_detector_arb_pkg: shared types and widths for the pattern-memory arbiter
package eth_frame_detector_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} arb_state_t;
  localparam int STAT_GRANT_W = 32;
  localparam int STAT_TO_W = 16;
  function automatic int tmo_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: round-robin pick of the first set request after index last, with wrap
module rr_priority_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    // wrapped candidates first, then those above last override them
    for (int j = N - 1; j >= 0; j--)
      if (req[j] && j <= int'(last)) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = $clog2(N)'(j);
      end
    for (int j = N - 1; j >= 0; j--)
      if (req[j] && j > int'(last)) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = $clog2(N)'(j);
      end
  end
endmodule

// File: rtl/eth_frame_detector_mem_arbiter.sv
// eth_frame_detector_mem_arbiter: round-robin arbiter sharing one pattern-memory port, with ack timeout.
// Optional grant/timeout statistics under ETH_FRAME_DETECTOR_ARB_STATS_EN.
module eth_frame_detector_mem_arbiter
  import eth_frame_detector_arb_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 11,
  parameter int C_NUM_REQ    = 2,
  parameter int C_TIMEOUT    = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
`ifdef ETH_FRAME_DETECTOR_ARB_STATS_EN
  input  logic                              stat_clr,
  output logic [C_NUM_REQ*STAT_GRANT_W-1:0] stat_grants,
  output logic [STAT_TO_W-1:0]              stat_timeouts,
`endif
  input  logic [C_NUM_REQ-1:0]              req_valid,
  input  logic [C_NUM_REQ-1:0]              req_we,
  input  logic [C_NUM_REQ*C_ADDR_WIDTH-1:0] req_addr,
  input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_wdata,
  output logic [C_NUM_REQ-1:0]              req_ack,
  output logic                              req_err,
  output logic [C_DATA_WIDTH-1:0]           req_rdata,
  output logic                              mem_req,
  output logic                              mem_we,
  input  logic                              mem_ack,
  output logic [C_ADDR_WIDTH-1:0]           mem_addr,
  output logic [C_DATA_WIDTH-1:0]           mem_wdata,
  input  logic [C_DATA_WIDTH-1:0]           mem_rdata
);
  localparam int IW = $clog2(C_NUM_REQ);
  localparam int TW = tmo_cnt_w(C_TIMEOUT);
  arb_state_t state;
  logic [IW-1:0] last, pick_idx;
  logic [C_NUM_REQ-1:0] pick;
  logic [TW-1:0] cnt;
  logic tmo;
  rr_priority_picker #(.N(C_NUM_REQ)) u_pick (
    .req  (req_valid),
    .last (last),
    .grant(pick),
    .idx  (pick_idx)
  );
  assign tmo = (C_TIMEOUT != 0) && (cnt == TW'(C_TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= IW'(C_NUM_REQ - 1);
      cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      req_ack <= '0;
      req_err <= 1'b0;
      req_rdata <= '0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: if (|pick) begin
          last <= pick_idx;
          cnt <= '0;
          mem_req <= 1'b1;
          mem_we <= req_we[pick_idx];
          mem_addr <= req_addr[pick_idx*C_ADDR_WIDTH +: C_ADDR_WIDTH];
          mem_wdata <= req_wdata[pick_idx*C_DATA_WIDTH +: C_DATA_WIDTH];
          state <= ISSUE;
        end
        ISSUE: if (mem_ack || tmo) begin
          mem_req <= 1'b0;
          req_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
          req_err <= !mem_ack;
          req_ack[last] <= 1'b1;
          state <= DONE;
        end else
          cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ETH_FRAME_DETECTOR_ARB_STATS_EN
  logic grant_ev, to_ev;
  assign grant_ev = (state == IDLE) && |pick;
  assign to_ev = (state == ISSUE) && !mem_ack && tmo;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_timeouts <= '0;
    end else if (stat_clr) begin
      stat_grants <= '0;
      stat_timeouts <= '0;
    end else begin
      if (to_ev && !(&stat_timeouts)) stat_timeouts <= stat_timeouts + 1'b1;
      for (int i = 0; i < C_NUM_REQ; i++)
        if (grant_ev && pick[i] && !(&stat_grants[i*STAT_GRANT_W +: STAT_GRANT_W]))
          stat_grants[i*STAT_GRANT_W +: STAT_GRANT_W] <= stat_grants[i*STAT_GRANT_W +: STAT_GRANT_W] + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_eth_frame_detector_mem_arbiter.sv
// tb_eth_frame_detector_mem_arbiter: directed table-driven bench for the memory arbiter (C_TIMEOUT=4)
module tb_eth_frame_detector_mem_arbiter;
  localparam int NOACK = 99;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_we = '0, req_ack;
  logic [21:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic req_err, mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] req_rdata, mem_wdata, mem_rdata = '0;
  logic [10:0] mem_addr;
`ifdef ETH_FRAME_DETECTOR_ARB_STATS_EN
  logic stat_clr = 1'b0;
  logic [63:0] stat_grants;
  logic [15:0] stat_timeouts;
`endif
  int cyc = 0, last_ack = 0, errs = 0, checks = 0;

  eth_frame_detector_mem_arbiter #(.C_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ETH_FRAME_DETECTOR_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_grants(stat_grants), .stat_timeouts(stat_timeouts),
`endif
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] valid, we;
    logic [10:0] a0, a1;
    logic [31:0] d0, d1;
    int delay;
    logic [31:0] mdata;
    int g;
    logic ewe;
    logic [10:0] eaddr;
    logic [31:0] ewdata, erdata;
    logic eerr;
    int ecyc, egap;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input string nm);
    int n = 0, k = 0;
    logic [1:0] ea;
    ea = 2'b01 << v.g;
    req_valid = v.valid;
    req_we = v.we;
    req_addr = {v.a1, v.a0};
    req_wdata = {v.d1, v.d0};
    step;
    chk({nm, " mem_req"}, 64'(mem_req), 64'd1);
    chk({nm, " mem_addr"}, 64'(mem_addr), 64'(v.eaddr));
    chk({nm, " mem_we"}, 64'(mem_we), 64'(v.ewe));
    chk({nm, " mem_wdata"}, 64'(mem_wdata), 64'(v.ewdata));
    while (req_ack == 2'b00 && k < 20) begin
      if (mem_req) n++;
      mem_ack = mem_req && (n - 1 == v.delay);
      mem_rdata = v.mdata;
      step;
      mem_ack = 1'b0;
      k++;
    end
    chk({nm, " req_ack"}, 64'(req_ack), 64'(ea));
    chk({nm, " req_err"}, 64'(req_err), 64'(v.eerr));
    chk({nm, " req_rdata"}, 64'(req_rdata), 64'(v.erdata));
    chk({nm, " mem_req cycles"}, 64'(n), 64'(v.ecyc));
    chk({nm, " mem_req low"}, 64'(mem_req), 64'd0);
    if (v.egap != 0) chk({nm, " ack gap"}, 64'(cyc - last_ack), 64'(v.egap));
    last_ack = cyc;
    step;
    chk({nm, " ack pulse"}, 64'(req_ack), 64'd0);
  endtask

  initial begin
    //          valid  we     a0      a1      d0            d1            delay  mdata         g  ewe   eaddr   ewdata        erdata        eerr  cyc gap
    tbl[0]  = '{2'b01, 2'b00, 11'h123, 11'h000, 32'h0,        32'h0,        3,     32'hDEADBEEF, 0, 1'b0, 11'h123, 32'h0,        32'hDEADBEEF, 1'b0, 4, 0};
    tbl[1]  = '{2'b10, 2'b10, 11'h000, 11'h7FF, 32'h0,        32'h0000A5A5, 1,     32'h11111111, 1, 1'b1, 11'h7FF, 32'h0000A5A5, 32'h0,        1'b0, 2, 0};
    tbl[2]  = '{2'b11, 2'b00, 11'h010, 11'h020, 32'h0,        32'h0,        0,     32'hA0000000, 0, 1'b0, 11'h010, 32'h0,        32'hA0000000, 1'b0, 1, 3};
    tbl[3]  = '{2'b11, 2'b00, 11'h010, 11'h020, 32'h0,        32'h0,        0,     32'hA0000001, 1, 1'b0, 11'h020, 32'h0,        32'hA0000001, 1'b0, 1, 3};
    tbl[4]  = '{2'b11, 2'b00, 11'h010, 11'h020, 32'h0,        32'h0,        0,     32'hA0000002, 0, 1'b0, 11'h010, 32'h0,        32'hA0000002, 1'b0, 1, 3};
    tbl[5]  = '{2'b11, 2'b00, 11'h010, 11'h020, 32'h0,        32'h0,        0,     32'hA0000003, 1, 1'b0, 11'h020, 32'h0,        32'hA0000003, 1'b0, 1, 3};
    tbl[6]  = '{2'b11, 2'b00, 11'h010, 11'h020, 32'h0,        32'h0,        0,     32'hA0000004, 0, 1'b0, 11'h010, 32'h0,        32'hA0000004, 1'b0, 1, 3};
    tbl[7]  = '{2'b11, 2'b00, 11'h010, 11'h020, 32'h0,        32'h0,        0,     32'hA0000005, 1, 1'b0, 11'h020, 32'h0,        32'hA0000005, 1'b0, 1, 3};
    tbl[8]  = '{2'b01, 2'b00, 11'h045, 11'h000, 32'h0,        32'h0,        NOACK, 32'hBAD0BAD0, 0, 1'b0, 11'h045, 32'h0,        32'h0,        1'b1, 4, 0};
    tbl[9]  = '{2'b11, 2'b01, 11'h001, 11'h3A0, 32'h12345678, 32'h0,        2,     32'hCAFEF00D, 1, 1'b0, 11'h3A0, 32'h0,        32'hCAFEF00D, 1'b0, 3, 0};
    tbl[10] = '{2'b01, 2'b01, 11'h001, 11'h000, 32'h12345678, 32'h0,        0,     32'hFFFFFFFF, 0, 1'b1, 11'h001, 32'h12345678, 32'h0,        1'b0, 1, 3};

    step;
    step;
    chk("reset mem_req", 64'(mem_req), 64'd0);
    chk("reset req_ack", 64'(req_ack), 64'd0);
    chk("reset req_err", 64'(req_err), 64'd0);
    chk("reset req_rdata", 64'(req_rdata), 64'd0);
    chk("reset mem_addr", 64'(mem_addr), 64'd0);
    chk("reset mem_we", 64'(mem_we), 64'd0);
    rst_n = 1'b1;
    step;

    for (int i = 0; i < 11; i++) begin
      run(tbl[i], $sformatf("vec%0d", i));
      if (tbl[i].delay == NOACK) begin
        req_valid = 2'b00;
        step;
        mem_ack = 1'b1;
        mem_rdata = 32'h55555555;
        step;
        mem_ack = 1'b0;
        chk("late ack rdata", 64'(req_rdata), 64'd0);
        chk("late ack err", 64'(req_err), 64'd1);
        chk("late ack req_ack", 64'(req_ack), 64'd0);
        step;
        chk("late ack mem_req", 64'(mem_req), 64'd0);
        chk("late ack req_ack 2", 64'(req_ack), 64'd0);
      end
    end

    // reset mid-ISSUE after requester 0 was granted: requester 0 must still win first afterwards
    req_valid = 2'b01;
    req_we = 2'b00;
    req_addr = {11'h0BB, 11'h0AA};
    step;
    chk("rst pre mem_req", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async mem_req", 64'(mem_req), 64'd0);
    req_valid = 2'b00;
    step;
    chk("rst no ack", 64'(req_ack), 64'd0);
    step;
    chk("rst no ack 2", 64'(req_ack), 64'd0);
    rst_n = 1'b1;
    step;
    req_valid = 2'b11;
    step;
    chk("post rst mem_req", 64'(mem_req), 64'd1);
    chk("post rst grant0 addr", 64'(mem_addr), 64'h0AA);
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    chk("post rst req_ack", 64'(req_ack), 64'd1);
    req_valid = 2'b00;
    step;

`ifdef ETH_FRAME_DETECTOR_ARB_STATS_EN
    stat_clr = 1'b1;
    step;
    stat_clr = 1'b0;
    chk("stat clr0 grants", stat_grants, 64'd0);
    run('{2'b01, 2'b00, 11'h100, 11'h0, 32'h0, 32'h0, 0, 32'h1, 0, 1'b0, 11'h100, 32'h0, 32'h1, 1'b0, 1, 0}, "st0");
    run('{2'b01, 2'b00, 11'h101, 11'h0, 32'h0, 32'h0, NOACK, 32'h2, 0, 1'b0, 11'h101, 32'h0, 32'h0, 1'b1, 4, 0}, "st1");
    run('{2'b01, 2'b00, 11'h102, 11'h0, 32'h0, 32'h0, 1, 32'h3, 0, 1'b0, 11'h102, 32'h0, 32'h3, 1'b0, 2, 0}, "st2");
    req_valid = 2'b00;
    chk("stat grants0", 64'(stat_grants[31:0]), 64'd3);
    chk("stat grants1", 64'(stat_grants[63:32]), 64'd0);
    chk("stat timeouts", 64'(stat_timeouts), 64'd1);
    stat_clr = 1'b1;
    step;
    stat_clr = 1'b0;
    chk("stat clr grants", stat_grants, 64'd0);
    chk("stat clr timeouts", 64'(stat_timeouts), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
